// File: rtl/fd_dram_bridge_pkg.sv
// Shared types and helpers for the FD <-> DRAM bridge.
// Holds the bridge FSM state encoding, the FD logical record layout,
// the DRAM byte layout and the layout conversion used by FD and the bridge.
package fd_dram_bridge_pkg;

  // DRAM byte address of record 0 and log2 of the record size in bytes.
  localparam logic [16:0] DEFAULT_BASE_ADDR      = 17'h10000;
  localparam int          DEFAULT_REC_BYTES_LOG2 = 3;

  // Bridge FSM states; names follow the handshake each state waits on.
  typedef enum logic [2:0] {
    B_IDLE       = 3'd0,
    B_C_IN_VALID = 3'd1,
    B_ARREADY    = 3'd2,
    B_RVALID     = 3'd3,
    B_AWREADY    = 3'd4,
    B_WVALID     = 3'd5,
    B_FINISH     = 3'd6
  } bridge_state;

  // Logical FD record: {D_man_Info, res_info}, one 32-bit word each.
  typedef logic [31:0] d_man_info;
  typedef logic [31:0] res_info;

  typedef struct packed {
    d_man_info man_info;
    res_info   res;
  } fd_record;

  // DRAM layout: same two 32-bit halves, each stored byte-reversed.
  typedef struct packed {
    logic [31:0] hi_word;
    logic [31:0] lo_word;
  } dram_data;

  // Reverse the byte order inside one 32-bit word.
  function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Logical <-> DRAM layout conversion. The transform is an involution,
  // so the same function serves writes (record to DRAM) and reads
  // (DRAM back to record).
  function automatic dram_data to_dram_layout(input fd_record rec);
    dram_data d;
    d.hi_word = swap_bytes32(rec.man_info);
    d.lo_word = swap_bytes32(rec.res);
    return d;
  endfunction

endpackage

// File: rtl/fd_dram_bridge.sv
// FD controller to DRAM bridge.
// Accepts one single-beat request from FD and runs it as a single AXI4-Lite
// read (AR, R) or write (AW, W, B). Data is converted between the FD logical
// record layout and the DRAM byte layout on the way through.
module fd_dram_bridge
  import fd_dram_bridge_pkg::*;
#(
  parameter logic [16:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          REC_BYTES_LOG2 = DEFAULT_REC_BYTES_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  // FD side
  input  logic        C_in_valid,
  input  logic        C_r_wb,
  input  logic [7:0]  C_addr,
  input  logic [63:0] C_data_w,
  output logic        C_out_valid,
  output logic [63:0] C_data_r,
  // AXI4-Lite read address
  output logic        AR_VALID,
  output logic [16:0] AR_ADDR,
  input  logic        AR_READY,
  // AXI4-Lite read data
  input  logic        R_VALID,
  input  logic [63:0] R_DATA,
  input  logic [1:0]  R_RESP,
  output logic        R_READY,
  // AXI4-Lite write address
  output logic        AW_VALID,
  output logic [16:0] AW_ADDR,
  input  logic        AW_READY,
  // AXI4-Lite write data
  output logic        W_VALID,
  output logic [63:0] W_DATA,
  input  logic        W_READY,
  // AXI4-Lite write response
  input  logic        B_VALID,
  input  logic [1:0]  B_RESP,
  output logic        B_READY
);

  bridge_state state_r;
  bridge_state state_s;

  logic        r_wb_r;
  logic [16:0] addr_r;
  logic [63:0] wdata_r;
  logic [63:0] rdata_r;
  logic        out_valid_r;

  logic        accept_s;
  logic        rd_done_s;
  logic        wr_done_s;
  logic [16:0] rec_offset_s;
  logic [16:0] req_addr_s;

  logic        ar_valid_s;
  logic        r_ready_s;
  logic        aw_valid_s;
  logic        w_valid_s;
  logic        b_ready_s;

  // Response codes carry no information the FD side can act on.
  logic        unused_resp_s;
  assign unused_resp_s = ^{R_RESP, B_RESP};

  // Record index to DRAM byte address; the index range never wraps.
  assign rec_offset_s = {9'd0, C_addr} << REC_BYTES_LOG2;
  assign req_addr_s   = BASE_ADDR + rec_offset_s;

  assign accept_s  = (state_r == B_IDLE)   && C_in_valid;
  assign rd_done_s = (state_r == B_RVALID) && R_VALID;
  assign wr_done_s = (state_r == B_FINISH) && B_VALID;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= B_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and handshake decode; handshakes depend only on state_r.
  always_comb begin
    state_s    = state_r;
    ar_valid_s = 1'b0;
    r_ready_s  = 1'b0;
    aw_valid_s = 1'b0;
    w_valid_s  = 1'b0;
    b_ready_s  = 1'b0;
    case (state_r)
      B_IDLE: begin
        if (C_in_valid) begin
          state_s = B_C_IN_VALID;
        end else begin
          state_s = B_IDLE;
        end
      end
      B_C_IN_VALID: begin
        if (r_wb_r) begin
          state_s = B_ARREADY;
        end else begin
          state_s = B_AWREADY;
        end
      end
      B_ARREADY: begin
        ar_valid_s = 1'b1;
        if (AR_READY) begin
          state_s = B_RVALID;
        end else begin
          state_s = B_ARREADY;
        end
      end
      B_RVALID: begin
        r_ready_s = 1'b1;
        if (R_VALID) begin
          state_s = B_IDLE;
        end else begin
          state_s = B_RVALID;
        end
      end
      B_AWREADY: begin
        aw_valid_s = 1'b1;
        if (AW_READY) begin
          state_s = B_WVALID;
        end else begin
          state_s = B_AWREADY;
        end
      end
      B_WVALID: begin
        w_valid_s = 1'b1;
        if (W_READY) begin
          state_s = B_FINISH;
        end else begin
          state_s = B_WVALID;
        end
      end
      B_FINISH: begin
        b_ready_s = 1'b1;
        if (B_VALID) begin
          state_s = B_IDLE;
        end else begin
          state_s = B_FINISH;
        end
      end
      default: begin
        state_s = B_IDLE;
      end
    endcase
  end

  // Request capture: direction, address and DRAM-layout write data are held
  // for the whole transaction so AXI address/data stay stable under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_r  <= 1'b0;
      addr_r  <= 17'd0;
      wdata_r <= 64'd0;
    end else if (accept_s) begin
      r_wb_r  <= C_r_wb;
      addr_r  <= req_addr_s;
      wdata_r <= to_dram_layout(C_data_w);
    end else begin
      r_wb_r  <= r_wb_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Completion: one-cycle strobe, read data kept until the next read ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rdata_r     <= 64'd0;
    end else begin
      out_valid_r <= rd_done_s | wr_done_s;
      if (rd_done_s) begin
        rdata_r <= to_dram_layout(R_DATA);
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign AR_VALID    = ar_valid_s;
  assign AR_ADDR     = addr_r;
  assign R_READY     = r_ready_s;
  assign AW_VALID    = aw_valid_s;
  assign AW_ADDR     = addr_r;
  assign W_VALID     = w_valid_s;
  assign W_DATA      = wdata_r;
  assign B_READY     = b_ready_s;
  assign C_out_valid = out_valid_r;
  assign C_data_r    = rdata_r;

endmodule

// File: tb/tb_fd_dram_bridge.sv
// Self-checking bench for fd_dram_bridge: a table of directed transactions,
// hand-written reset sequences and randomized traffic against a record-level
// model (logical memory contents, address arithmetic, latency formula).
module tb_fd_dram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;
  logic        AR_VALID;
  logic [16:0] AR_ADDR;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_READY;
  logic        AW_VALID;
  logic [16:0] AW_ADDR;
  logic        AW_READY;
  logic        W_VALID;
  logic [63:0] W_DATA;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY;

  int n_vec = 0;
  int n_err = 0;

  // ref_mem: logical record contents; dram_mem: bytes as the DRAM holds them.
  logic [63:0] ref_mem  [256];
  logic [63:0] dram_mem [256];
  logic [63:0] last_rd;

  fd_dram_bridge dut (
    .clk(clk), .rst(rst),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [7:0]  idx;
    logic [63:0] wd;
    int          d_ar, d_r, d_aw, d_w, d_b;
    int          spur_cyc;
    logic [16:0] exp_addr;
    logic [63:0] exp_w;
    logic [63:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  // Byte i of the record lands at the mirrored byte position of its half.
  function automatic logic [63:0] ref_swap(input logic [63:0] d);
    logic [63:0] o;
    o = 64'd0;
    for (int i = 0; i < 8; i++) begin
      o[8*((i/4)*4 + 3 - (i%4)) +: 8] = d[8*i +: 8];
    end
    return o;
  endfunction

  function automatic int addr_to_idx(input logic [16:0] a);
    if (a < 17'h10000 || a > 17'h107F8 || a[2:0] != 3'd0) return -1;
    return int'((a - 17'h10000) >> 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    C_in_valid = 1'b0;
    C_r_wb     = 1'($urandom_range(0, 1));
    C_addr     = 8'($urandom_range(0, 255));
    C_data_w   = {$urandom, $urandom};
    AR_READY   = 1'b0;
    R_VALID    = 1'b0;
    R_DATA     = {$urandom, $urandom};
    R_RESP     = 2'($urandom_range(0, 3));
    AW_READY   = 1'b0;
    W_READY    = 1'b0;
    B_VALID    = 1'b0;
    B_RESP     = 2'($urandom_range(0, 3));
  endtask

  task automatic rand_inputs();
    idle_inputs();
    C_in_valid = 1'($urandom_range(0, 1));
    AR_READY   = 1'($urandom_range(0, 1));
    R_VALID    = 1'($urandom_range(0, 1));
    AW_READY   = 1'($urandom_range(0, 1));
    W_READY    = 1'($urandom_range(0, 1));
    B_VALID    = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(C_out_valid), 64'd0);
    chk({tag, "_data_r"},    C_data_r,          64'd0);
    chk({tag, "_ar_valid"},  64'(AR_VALID),     64'd0);
    chk({tag, "_ar_addr"},   64'(AR_ADDR),      64'd0);
    chk({tag, "_r_ready"},   64'(R_READY),      64'd0);
    chk({tag, "_aw_valid"},  64'(AW_VALID),     64'd0);
    chk({tag, "_aw_addr"},   64'(AW_ADDR),      64'd0);
    chk({tag, "_w_valid"},   64'(W_VALID),      64'd0);
    chk({tag, "_w_data"},    W_DATA,            64'd0);
    chk({tag, "_b_ready"},   64'(B_READY),      64'd0);
  endtask

  // One FD request played against a DRAM slave with per-channel stalls.
  // Cycle 0 is the C_in_valid cycle; outputs are sampled 1 time unit after
  // each rising edge and slave inputs for that cycle are driven right away.
  task automatic run_txn(input bit rd, input logic [7:0] idx, input logic [63:0] wd,
                         input int d_ar, input int d_r, input int d_aw,
                         input int d_w, input int d_b, input int spur_cyc,
                         input logic [16:0] exp_addr, input logic [63:0] exp_w,
                         input logic [63:0] exp_r, input int exp_lat);
    int n_ar = 0;
    int n_r = 0;
    int n_aw = 0;
    int n_w = 0;
    int n_b = 0;
    int mi;
    bit done = 1'b0;
    logic [16:0] rd_addr = 17'd0;
    logic [16:0] wr_addr = 17'd0;
    @(posedge clk); #1;
    idle_inputs();
    C_in_valid = 1'b1;
    C_r_wb     = rd;
    C_addr     = idx;
    C_data_w   = wd;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (cyc == spur_cyc) C_in_valid = 1'b1;
      if (rd) chk("write_chan_during_read", 64'({AW_VALID, W_VALID, B_READY}), 64'd0);
      else    chk("read_chan_during_write", 64'({AR_VALID, R_READY}), 64'd0);
      if (C_out_valid) begin
        done = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_lat));
        if (rd) begin
          chk("read_data", C_data_r, exp_r);
          last_rd = exp_r;
        end else begin
          chk("data_r_hold_on_write", C_data_r, last_rd);
        end
      end
      if (AR_VALID) begin
        chk("ar_addr", 64'(AR_ADDR), 64'(exp_addr));
        AR_READY = (n_ar >= d_ar);
        if (AR_READY) rd_addr = AR_ADDR;
        n_ar++;
      end
      if (R_READY) begin
        if (n_r >= d_r) begin
          R_VALID = 1'b1;
          mi = addr_to_idx(rd_addr);
          R_DATA = (mi < 0) ? 64'hBAD0_BAD0_BAD0_BAD0 : dram_mem[mi];
        end
        n_r++;
      end
      if (AW_VALID) begin
        chk("aw_addr", 64'(AW_ADDR), 64'(exp_addr));
        AW_READY = (n_aw >= d_aw);
        if (AW_READY) wr_addr = AW_ADDR;
        n_aw++;
      end
      if (W_VALID) begin
        chk("w_data", W_DATA, exp_w);
        W_READY = (n_w >= d_w);
        if (W_READY) begin
          mi = addr_to_idx(wr_addr);
          if (mi >= 0) dram_mem[mi] = W_DATA;
        end
        n_w++;
      end
      if (B_READY) begin
        B_VALID = (n_b >= d_b);
        n_b++;
      end
    end
    chk("completion", 64'(done), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk("out_valid_single_cycle", 64'(C_out_valid), 64'd0);
    chk("data_r_held", C_data_r, last_rd);
  endtask

  initial begin
    bit          rd;
    logic [7:0]  idx;
    logic [63:0] wd;
    int          d_ar, d_r, d_aw, d_w, d_b, sp, sel;
    logic [16:0] ea;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = {$urandom, $urandom};
      dram_mem[i] = ref_swap(ref_mem[i]);
    end
    ref_mem[3]  = 64'h0123_4567_89AB_CDEF;
    dram_mem[3] = 64'h6745_2301_EFCD_AB89;
    last_rd     = 64'd0;

    //            rd    idx    wd                      ar r aw w b spur addr       exp_w                   exp_r                   lat
    vecs[0] = '{1'b1, 8'h03, 64'd0,                  0, 0, 0, 0, 0, 0, 17'h10018, 64'd0,                  64'h0123_4567_89AB_CDEF, 4};
    vecs[1] = '{1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, 0, 17'h107F8, 64'h6745_2301_EFCD_AB89, 64'd0,                  5};
    vecs[2] = '{1'b1, 8'h03, 64'd0,                  3, 5, 0, 0, 0, 0, 17'h10018, 64'd0,                  64'h0123_4567_89AB_CDEF, 12};
    vecs[3] = '{1'b0, 8'h00, 64'hDEAD_BEEF_0011_2233, 0, 0, 2, 2, 2, 0, 17'h10000, 64'hEFBE_ADDE_3322_1100, 64'd0,                  11};
    vecs[4] = '{1'b0, 8'h07, 64'hAAAA_5555_0F0F_F0F0, 0, 0, 0, 0, 0, 3, 17'h10038, 64'h5555_AAAA_F0F0_0F0F, 64'd0,                  5};
    vecs[5] = '{1'b1, 8'h07, 64'd0,                  0, 0, 0, 0, 0, 0, 17'h10038, 64'd0,                  64'hAAAA_5555_0F0F_F0F0, 4};
    vecs[6] = '{1'b1, 8'hFF, 64'd0,                  0, 0, 0, 0, 0, 2, 17'h107F8, 64'd0,                  64'h0123_4567_89AB_CDEF, 4};
    vecs[7] = '{1'b1, 8'h00, 64'd0,                  1, 0, 0, 0, 0, 0, 17'h10000, 64'd0,                  64'hDEAD_BEEF_0011_2233, 5};

    // Reset values: two reset cycles with random inputs, then one idle cycle.
    rst = 1'b1;
    rand_inputs();
    @(posedge clk); #1;
    check_all_zero("rst_c1");
    rand_inputs();
    @(posedge clk); #1;
    check_all_zero("rst_c2");
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    check_all_zero("post_rst");

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].rd, vecs[v].idx, vecs[v].wd, vecs[v].d_ar, vecs[v].d_r,
              vecs[v].d_aw, vecs[v].d_w, vecs[v].d_b, vecs[v].spur_cyc,
              vecs[v].exp_addr, vecs[v].exp_w, vecs[v].exp_r, vecs[v].exp_lat);
      if (!vecs[v].rd) ref_mem[vecs[v].idx] = vecs[v].wd;
    end

    // Reset while waiting in the write-data phase: the write is abandoned.
    @(posedge clk); #1;
    idle_inputs();
    C_in_valid = 1'b1;
    C_r_wb     = 1'b0;
    C_addr     = 8'd9;
    C_data_w   = ~ref_mem[9];
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (AW_VALID) AW_READY = 1'b1;
    end
    chk("w_valid_before_reset", 64'(W_VALID), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    check_all_zero("mid_txn_rst");
    last_rd = 64'd0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      chk("no_out_valid_after_abort", 64'(C_out_valid), 64'd0);
      chk("no_w_valid_after_abort", 64'(W_VALID), 64'd0);
    end
    run_txn(1'b1, 8'd9, 64'd0, 0, 0, 0, 0, 0, 0, 17'h10048, 64'd0, ref_mem[9], 4);

    // Randomized traffic against the record-level model.
    for (int t = 0; t < 60; t++) begin
      rd   = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 3));
      idx  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      wd   = {$urandom, $urandom};
      d_ar = int'($urandom_range(0, 3));
      d_r  = int'($urandom_range(0, 3));
      d_aw = int'($urandom_range(0, 3));
      d_w  = int'($urandom_range(0, 3));
      d_b  = int'($urandom_range(0, 3));
      sp   = int'($urandom_range(0, 3));
      ea   = 17'h10000 + 17'(idx) * 17'd8;
      if (rd) begin
        run_txn(1'b1, idx, wd, d_ar, d_r, 0, 0, 0, sp, ea, 64'd0, ref_mem[idx], 4 + d_ar + d_r);
      end else begin
        run_txn(1'b0, idx, wd, 0, 0, d_aw, d_w, d_b, sp, ea, ref_swap(wd), 64'd0, 5 + d_aw + d_w + d_b);
        ref_mem[idx] = wd;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
